// File: rtl/motoro3_pkg.sv
// Shared definitions for the motoro3 PWM ramp controller: on-time width,
// default on-time limits, FSM state encodings and the minimum-on helper.
package motoro3_pkg;

    localparam int LEN_W = 12;

    localparam logic [LEN_W-1:0] MIN_LEN_DEF = 12'h020;
    localparam logic [LEN_W-1:0] MAX_LEN_DEF = 12'hFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } state_e;

    // On-times below the MOS driver limit cannot be produced, so they become 0.
    function automatic logic [LEN_W-1:0] minOnLen(input logic [LEN_W-1:0] len,
                                                  input logic [LEN_W-1:0] minLen);
        return (len < minLen) ? '0 : len;
    endfunction

endpackage

// File: rtl/motoro3_tick_div.sv
// Commutation-step pulse divider: asserts upd on every TICK_DIV-th
// m3cntLast1 pulse. clr holds/restarts the count at 0 and masks upd.
module motoro3_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic nRst,
    input  logic m3cntLast1,
    input  logic clr,
    output logic upd
);

    localparam logic [3:0] LAST = 4'(TICK_DIV - 1);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // Count pulses and wrap after LAST; a clear always wins over counting.
    always_comb begin
        cnt_d = cnt_q;
        upd   = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (m3cntLast1) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                upd   = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Divider count register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/motoro3_pwm_ramp_ctrl.sv
// Soft-start/soft-stop on-time scheduler for the 3-phase PWM generator.
// Moves the on-time toward the target in bounded steps only at divided
// commutation-step boundaries, enforces the minimum on-time and gives an
// immediate fault shutdown.
// Optional: define MOTORO3_PWM_RAMP_STALL_GUARD_EN to hold the ramp at
// MIN_LEN while no commutation period has been measured (plLen == 0).
module motoro3_pwm_ramp_ctrl
    import motoro3_pkg::*;
#(
    parameter logic [LEN_W-1:0] MIN_LEN  = MIN_LEN_DEF,
    parameter logic [LEN_W-1:0] MAX_LEN  = MAX_LEN_DEF,
    parameter int               TICK_DIV = 4
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             m3cntLast1,
    input  logic             enable,
    input  logic [LEN_W-1:0] targetLen,
    input  logic [LEN_W-1:0] rampStep,
    input  logic             fault,
    input  logic             faultClr,
    input  logic [15:0]      plLen,
    output logic [LEN_W-1:0] m3r_pwmLenWant,
    output logic             pwmActive,
    output logic             atTarget,
    output logic [2:0]       state
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cur_q, cur_d;
    logic [LEN_W-1:0] outLen_q, outLen_d;

    logic [LEN_W-1:0] goal;
    logic [LEN_W-1:0] stepEff;
    logic [LEN_W:0]   sumUp;
    logic [LEN_W:0]   diffDn;
    logic [LEN_W-1:0] upNext;
    logic [LEN_W-1:0] dnNext;
    logic             stall;
    logic             divClr;
    logic             upd;

`ifdef MOTORO3_PWM_RAMP_STALL_GUARD_EN
    assign stall = (plLen == 16'd0);
`else
    logic unusedPlLen;
    assign unusedPlLen = ^plLen;
    assign stall       = 1'b0;
`endif

    motoro3_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tickDiv (
        .clk        (clk),
        .nRst       (nRst),
        .m3cntLast1 (m3cntLast1),
        .clr        (divClr),
        .upd        (upd)
    );

    // Goal, effective step and the saturating up/down candidates for cur.
    always_comb begin
        goal    = enable ? ((targetLen > MAX_LEN) ? MAX_LEN : targetLen) : '0;
        stepEff = (rampStep == '0) ? {{(LEN_W-1){1'b0}}, 1'b1} : rampStep;
        sumUp   = {1'b0, cur_q} + {1'b0, stepEff};
        diffDn  = {1'b0, cur_q} - {1'b0, stepEff};
        upNext  = (sumUp > {1'b0, goal}) ? goal : sumUp[LEN_W-1:0];
        if (stall && (upNext > MIN_LEN)) begin
            upNext = MIN_LEN;
        end
        dnNext  = (diffDn[LEN_W] || (diffDn[LEN_W-1:0] < goal)) ? goal : diffDn[LEN_W-1:0];
    end

    // Divider is parked in IDLE/FAULT and restarted on every edge that enters a ramp state.
    always_comb begin
        divClr = fault
              || (state_q == ST_IDLE) || (state_q == ST_FAULT)
              || ((state_q == ST_HOLD)      && (goal != cur_q))
              || ((state_q == ST_RAMP_UP)   && (goal <  cur_q))
              || ((state_q == ST_RAMP_DOWN) && (goal >  cur_q));
    end

    // Next-state and next-cur logic; fault overrides everything.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        if (fault) begin
            state_d = ST_FAULT;
            cur_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (enable && (goal != '0)) begin
                        state_d = ST_RAMP_UP;
                    end
                end
                ST_RAMP_UP: begin
                    if (goal < cur_q) begin
                        state_d = ST_RAMP_DOWN;
                    end else if (upd) begin
                        cur_d = upNext;
                        if (upNext == goal) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (goal > cur_q) begin
                        state_d = ST_RAMP_UP;
                    end else if (goal < cur_q) begin
                        state_d = ST_RAMP_DOWN;
                    end
                end
                ST_RAMP_DOWN: begin
                    if (goal > cur_q) begin
                        state_d = ST_RAMP_UP;
                    end else if (upd) begin
                        cur_d = dnNext;
                        if (dnNext == goal) begin
                            state_d = (goal == '0) ? ST_IDLE : ST_HOLD;
                        end
                    end
                end
                ST_FAULT: begin
                    cur_d = '0;
                    if (faultClr) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cur_d   = '0;
                end
            endcase
        end
        outLen_d = minOnLen(cur_d, MIN_LEN);
    end

    // State, internal on-time and output register all update on the same edge.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q  <= ST_IDLE;
            cur_q    <= '0;
            outLen_q <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            outLen_q <= outLen_d;
        end
    end

    assign m3r_pwmLenWant = outLen_q;
    assign pwmActive      = (outLen_q != '0);
    assign atTarget       = (state_q == ST_HOLD);
    assign state          = state_q;

endmodule
